fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 4, giving HI/LO latency of MULT/MULTU in cycles (range 1..63).
REQ-002 SHALL provide parameter DIV_CYCLES, default 32, giving HI/LO latency of DIV/DIVU in cycles (range 1..63).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_uses_rs, id_uses_rt, id_is_mfhilo, id_is_md  in  1 each  ID reads rs / reads rt / is MFHI or MFLO / is MULT(U) or DIV(U).
REQ-007 ex_rs, ex_rt  in  5 each  source register numbers held in ID_EX.
REQ-008 ex_memread  in  1, ex_rd  in  5  ID_EX holds a load and its destination.
REQ-009 ex_start_mult, ex_start_div  in  1 each  mult/div issues from EX this cycle.
REQ-010 mem_regwrite  in  1, mem_rd  in  5, mem_is_link  in  1  EX_MEM write-back info; link = JAL/JALR writing PC+4.
REQ-011 wb_regwrite  in  1, wb_rd  in  5  MEM_WB write-back info.
REQ-012 rs_fsel, rt_fsel  out  2 each  EX-stage operand select: 0 ID_EX value, 1 EX_MEM result, 2 EX_MEM PC+4, 3 WB result.
REQ-013 stall  out  1  hold PC and IF_ID; id_ex_flush  out  1  insert bubble into ID_EX.
REQ-014 md_busy  out  1  mult/div unit in progress.

Function
REQ-015 Select for ex_rs: 1 if mem_regwrite, mem_rd==ex_rs, mem_rd!=0, mem_is_link=0; 2 if same match with mem_is_link=1; else 3 if wb_regwrite, wb_rd==ex_rs, wb_rd!=0; else 0. rt_fsel identical using ex_rt.
REQ-016 EX_MEM match SHALL take priority over MEM_WB match; register 0 never forwarded.
REQ-017 rs_fsel/rt_fsel SHALL be combinational, same-cycle, with no latch inference.
REQ-018 Load-use hazard: ex_memread, ex_rd!=0, and (id_uses_rs and id_rs==ex_rd, or id_uses_rt and id_rt==ex_rd); combinational, asserts stall and id_ex_flush that cycle.
REQ-019 Mult/div FSM states IDLE, BUSY; 6-bit down counter md_cnt.
REQ-020 IDLE and ex_start_mult -> BUSY, md_cnt=MULT_CYCLES; IDLE and ex_start_div -> BUSY, md_cnt=DIV_CYCLES; both asserted -> div wins.
REQ-021 BUSY: md_cnt decrements each cycle; md_cnt==1 -> IDLE next edge, md_cnt=0.
REQ-022 md_busy = (state==BUSY); starts in BUSY are ignored, counter not reloaded.
REQ-023 MD hazard: md_busy and (id_is_mfhilo or id_is_md) asserts stall and id_ex_flush.
REQ-024 stall = load-use hazard OR MD hazard; id_ex_flush equals stall.
REQ-025 MD hazard releases in the cycle the FSM returns to IDLE; an N-cycle op stalls a dependent MFHI for exactly N cycles when it sits in ID the cycle after issue.

Reset
REQ-026 rst SHALL force state IDLE, md_cnt 0, md_busy 0 immediately, including mid-operation.
REQ-027 During reset, stall and id_ex_flush follow only the load-use term; fsel outputs remain combinational.

Configuration
REQ-028 With HAZ_STALL_COUNT_EN defined: extra output stall_cnt out 32, counts cycles with stall=1, wraps 0xFFFFFFFF->0, reset to 0.
REQ-029 Without HAZ_STALL_COUNT_EN: port stall_cnt and its register SHALL not exist; all other behaviour identical.

Verification
REQ-030 mem_regwrite=1, mem_rd=5, ex_rs=5, wb_rd=5, wb_regwrite=1 -> rs_fsel=1; then mem_is_link=1 -> rs_fsel=2; mem_regwrite=0 -> 3.
REQ-031 mem_rd=0, mem_regwrite=1, ex_rt=0 -> rt_fsel=0.
REQ-032 ex_memread=1, ex_rd=8, id_rt=8, id_uses_rt=1 -> stall=1, id_ex_flush=1 one cycle; id_uses_rt=0 -> stall=0.
REQ-033 ex_start_div pulse, id_is_mfhilo held 1 -> md_busy and stall high exactly 32 cycles, then 0.
REQ-034 ex_start_mult pulse, rst asserted 2 cycles later -> md_busy=0 immediately, stall=0 with id_is_mfhilo=1.
REQ-035 HAZ_STALL_COUNT_EN build: ex_start_mult with id_is_mfhilo held -> stall_cnt=4; preloaded 0xFFFFFFFF plus one stall -> 0.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use and mult/div hazard detection for the EX/ID stages.
// Optional stall cycle counter enabled with `define HAZ_STALL_COUNT_EN.
module fwd_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_mfhilo,
  input  logic       id_is_md,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       ex_start_mult,
  input  logic       ex_start_div,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       mem_is_link,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  output logic [1:0] rs_fsel,
  output logic [1:0] rt_fsel,
  output logic       stall,
  output logic       id_ex_flush,
`ifdef HAZ_STALL_COUNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic       md_busy
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic             load_use;
  logic             md_haz;

  // EX_MEM beats MEM_WB; register 0 is never forwarded
  function automatic logic [1:0] fsel(input logic [4:0] src,
                                      input logic       m_we,
                                      input logic [4:0] m_rd,
                                      input logic       m_link,
                                      input logic       w_we,
                                      input logic [4:0] w_rd);
    logic [1:0] sel;
    sel = 2'd0;
    if (m_we && (m_rd == src) && (m_rd != 5'd0))
      sel = m_link ? 2'd2 : 2'd1;
    else if (w_we && (w_rd == src) && (w_rd != 5'd0))
      sel = 2'd3;
    return sel;
  endfunction

  always_comb begin
    rs_fsel = fsel(ex_rs, mem_regwrite, mem_rd, mem_is_link, wb_regwrite, wb_rd);
    rt_fsel = fsel(ex_rt, mem_regwrite, mem_rd, mem_is_link, wb_regwrite, wb_rd);
  end

  always_comb begin
    load_use = ex_memread && (ex_rd != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    md_busy  = (state == BUSY);
    md_haz   = md_busy && (id_is_mfhilo || id_is_md);
    stall       = load_use || md_haz;
    id_ex_flush = load_use || md_haz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Divide wins over multiply; starts while busy are dropped
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (ex_start_div) begin
          state_nxt  = BUSY;
          md_cnt_nxt = CNT_W'(DIV_CYCLES);
        end else if (ex_start_mult) begin
          state_nxt  = BUSY;
          md_cnt_nxt = CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        if (md_cnt == CNT_W'(1)) begin
          state_nxt  = IDLE;
          md_cnt_nxt = '0;
        end else begin
          md_cnt_nxt = md_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        md_cnt_nxt = '0;
      end
    endcase
  end

`ifdef HAZ_STALL_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus random traffic vs. a
// cycle-indexed reference model (issue edge + latency window).
module tb_fwd_hazard_ctrl;

  localparam int MC = 4;
  localparam int DC = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_is_mfhilo, id_is_md;
  logic       ex_memread, ex_start_mult, ex_start_div;
  logic       mem_regwrite, mem_is_link, wb_regwrite;
  logic [1:0] rs_fsel, rt_fsel;
  logic       stall, id_ex_flush, md_busy;
`ifdef HAZ_STALL_COUNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference model: edge count, last accepted issue edge and its latency
  int edge_n   = 0;
  int md_start = 0;
  int md_len   = 0;
  int scnt     = 0;

  fwd_hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_mfhilo(id_is_mfhilo), .id_is_md(id_is_md),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_start_mult(ex_start_mult), .ex_start_div(ex_start_div),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_is_link(mem_is_link),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .rs_fsel(rs_fsel), .rt_fsel(rt_fsel),
    .stall(stall), .id_ex_flush(id_ex_flush),
`ifdef HAZ_STALL_COUNT_EN
    .stall_cnt(stall_cnt),
`endif
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy(input int e);
    return (md_len > 0) && (e >= md_start) && (e < md_start + md_len);
  endfunction

  function automatic logic [1:0] m_fsel(input logic [4:0] src);
    if (mem_regwrite && mem_rd == src && mem_rd != 0) return mem_is_link ? 2'd2 : 2'd1;
    if (wb_regwrite && wb_rd == src && wb_rd != 0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit m_stall();
    bit lu;
    lu = ex_memread && ex_rd != 0 &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    return lu || (!rst && m_busy(edge_n) && (id_is_mfhilo || id_is_md));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge, updating the model from pre-edge inputs
  task automatic tick();
    bit st;
    @(posedge clk);
    st = m_stall();
    if (rst) begin
      md_len = 0;
      scnt   = 0;
    end else begin
      if (st) scnt++;
      if (!m_busy(edge_n) && (ex_start_div || ex_start_mult)) begin
        md_start = edge_n + 1;
        md_len   = ex_start_div ? DC : MC;
      end
    end
    edge_n++;
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rs_fsel"}, int'(rs_fsel), int'(m_fsel(ex_rs)));
    chk({tag, ".rt_fsel"}, int'(rt_fsel), int'(m_fsel(ex_rt)));
    chk({tag, ".stall"}, int'(stall), int'(m_stall()));
    chk({tag, ".flush"}, int'(id_ex_flush), int'(m_stall()));
    chk({tag, ".md_busy"}, int'(md_busy), int'(!rst && m_busy(edge_n)));
`ifdef HAZ_STALL_COUNT_EN
    chk({tag, ".stall_cnt"}, int'(stall_cnt), scnt);
`endif
  endtask

  task automatic clear_in();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs, id_uses_rt, id_is_mfhilo, id_is_md} = '0;
    {ex_memread, ex_start_mult, ex_start_div} = '0;
    {mem_regwrite, mem_is_link, wb_regwrite} = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    md_len = 0;
    scnt = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int busy_cycles;
    clear_in();
    rst = 1'b1;
    #1;
    chk("reset.md_busy", int'(md_busy), 0);
    chk("reset.stall", int'(stall), 0);
    do_reset();
    chk_all("post_reset");

    // forwarding priority and link select
    mem_regwrite = 1; mem_rd = 5; ex_rs = 5; wb_rd = 5; wb_regwrite = 1; #1;
    chk("fwd.exmem", int'(rs_fsel), 1);
    mem_is_link = 1; #1;
    chk("fwd.link", int'(rs_fsel), 2);
    mem_regwrite = 0; #1;
    chk("fwd.wb", int'(rs_fsel), 3);
    clear_in();
    mem_rd = 0; mem_regwrite = 1; ex_rt = 0; #1;
    chk("fwd.r0", int'(rt_fsel), 0);
    clear_in();

    // load-use stall
    ex_memread = 1; ex_rd = 8; id_rt = 8; id_uses_rt = 1; #1;
    chk("lu.stall", int'(stall), 1);
    chk("lu.flush", int'(id_ex_flush), 1);
    id_uses_rt = 0; #1;
    chk("lu.nouse", int'(stall), 0);
    ex_rd = 0; id_uses_rt = 1; id_rt = 0; #1;
    chk("lu.r0", int'(stall), 0);
    clear_in();

    // divide holds a dependent MFHI for exactly DIV latency
    id_is_mfhilo = 1; ex_start_div = 1;
    tick();
    ex_start_div = 0; #1;
    busy_cycles = 0;
    for (int i = 0; i < DC + 8; i++) begin
      if (stall && md_busy) busy_cycles++;
      chk_all("div.win");
      tick();
    end
    chk("div.len", busy_cycles, DC);
    chk("div.done", int'(stall), 0);

    // reset aborts multiply mid-operation
    ex_start_mult = 1;
    tick();
    ex_start_mult = 0;
    tick();
    tick();
    chk("mult.busy", int'(md_busy), 1);
    rst = 1; md_len = 0; scnt = 0; #1;
    chk("rst.md_busy", int'(md_busy), 0);
    chk("rst.stall", int'(stall), 0);
    tick();
    rst = 0; #1;
    chk_all("rst.release");

    // start during busy is ignored; div wins over mult
    id_is_mfhilo = 0; id_is_md = 1; ex_start_mult = 1; ex_start_div = 1;
    tick();
    ex_start_div = 0;
    for (int i = 0; i < DC + 4; i++) begin
      chk_all("both");
      tick();
    end
    clear_in();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_is_mfhilo = 1'($urandom); id_is_md = ($urandom_range(0, 3) == 0);
      ex_memread = 1'($urandom);
      ex_start_mult = ($urandom_range(0, 9) == 0);
      ex_start_div  = ($urandom_range(0, 19) == 0);
      mem_regwrite = 1'($urandom); mem_is_link = ($urandom_range(0, 3) == 0);
      wb_regwrite = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1; md_len = 0; scnt = 0;
      end else begin
        rst = 0;
      end
      #1;
      chk_all("rand");
      tick();
    end
    rst = 0;
    clear_in();

`ifdef HAZ_STALL_COUNT_EN
    do_reset();
    id_is_mfhilo = 1; ex_start_mult = 1;
    tick();
    ex_start_mult = 0;
    for (int i = 0; i < MC + 3; i++) tick();
    chk("cnt.mult", int'(stall_cnt), MC);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
